attack_resolver: RTL and testbench

//  Consumes the dmg/accu pair produced by the move mux and resolves one attack per start pulse.

---
 rtl/attack_resolver.sv | 114 +++++++++++
 tb/tb_attack_resolver.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/attack_resolver.sv
// Resolves one attack per start pulse: LFSR roll, hit/miss decision, saturating HP
// subtraction on the defender, a one-cycle done strobe and the game-over latch.
module attack_resolver #(
  parameter int          HP_W      = 7,
  parameter int          HP_INIT   = 100,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            attacker,
  input  logic [4:0]      dmg,
  input  logic [4:0]      accu,
  input  logic            new_game,
  output logic [HP_W-1:0] hp_p1,
  output logic [HP_W-1:0] hp_p2,
  output logic            busy,
  output logic            done,
  output logic            hit,
  output logic [3:0]      roll,
  output logic            game_over
);

  localparam logic [HP_W-1:0] HP_RST = HP_W'(HP_INIT);

  typedef enum logic [2:0] {IDLE, ROLL, APPLY, DONE, OVER} state_t;

  state_t          state;
  logic [7:0]      lfsr;
  logic [7:0]      lfsr_nxt;
  logic [4:0]      dmg_q;
  logic [4:0]      accu_q;
  logic            att_q;
  logic [HP_W-1:0] dmg_ext;

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                              input logic [HP_W-1:0] d);
    return (hp <= d) ? '0 : hp - d;
  endfunction

  // x^8+x^6+x^5+x^4+1; the all-zero lockup state reloads the seed
  always_comb begin
    lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    if (lfsr == 8'h00) lfsr_nxt = LFSR_SEED;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= LFSR_SEED;
    else         lfsr <= lfsr_nxt;
  end

  assign dmg_ext = {{(HP_W-5){1'b0}}, dmg_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      hp_p1     <= HP_RST;
      hp_p2     <= HP_RST;
      hit       <= 1'b0;
      roll      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      game_over <= 1'b0;
      dmg_q     <= '0;
      accu_q    <= '0;
      att_q     <= 1'b0;
    end else if (new_game) begin
      // roll and the LFSR are deliberately left running
      state     <= IDLE;
      hp_p1     <= HP_RST;
      hp_p2     <= HP_RST;
      hit       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dmg_q  <= dmg;
          accu_q <= accu;
          att_q  <= attacker;
          roll   <= lfsr[3:0];
          busy   <= 1'b1;
          state  <= ROLL;
        end
        ROLL: begin
          hit   <= ({1'b0, roll} < accu_q);
          state <= APPLY;
        end
        APPLY: begin
          if (hit) begin
            if (att_q) hp_p1 <= sat_sub(hp_p1, dmg_ext);
            else       hp_p2 <= sat_sub(hp_p2, dmg_ext);
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (hp_p1 == '0 || hp_p2 == '0) begin
            game_over <= 1'b1;
            state     <= OVER;
          end else begin
            state <= IDLE;
          end
        end
        OVER:    state <= OVER;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_attack_resolver.sv
// Directed bench for attack_resolver: vector table of deterministic attacks plus
// hand sequences for abort, game-over, new_game and back-to-back start behaviour.
module tb_attack_resolver;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start, attacker, new_game;
  logic [4:0] dmg, accu;
  logic [6:0] hp_p1, hp_p2;
  logic       busy, done, hit, game_over;
  logic [3:0] roll;

  int tests = 0;
  int fails = 0;

  logic [7:0] lfsr_m;
  logic [3:0] exp_roll;

  attack_resolver #(.HP_W(7), .HP_INIT(100), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .resetn(resetn), .start(start), .attacker(attacker),
    .dmg(dmg), .accu(accu), .new_game(new_game),
    .hp_p1(hp_p1), .hp_p2(hp_p2), .busy(busy), .done(done),
    .hit(hit), .roll(roll), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, zero reloads seed
  always @(posedge clk or negedge resetn) begin
    if (!resetn)              lfsr_m <= 8'hA5;
    else if (lfsr_m == 8'h00) lfsr_m <= 8'hA5;
    else                      lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       att;
    logic [4:0] dmg;
    logic [4:0] accu;
    logic       exp_hit;
    logic [6:0] exp_p1;
    logic [6:0] exp_p2;
    logic       exp_over;
  } vec_t;

  vec_t vecs[8];

  // one full attack; operands are scrambled right after the latch edge
  task automatic run_attack(input vec_t v);
    @(negedge clk);
    start = 1'b1; attacker = v.att; dmg = v.dmg; accu = v.accu;
    exp_roll = lfsr_m[3:0];
    @(posedge clk); #1;
    start = 1'b0; dmg = v.dmg ^ 5'h1F; accu = v.accu ^ 5'h1F; attacker = ~v.att;
    chk("busy_k", busy, 1);
    chk("roll_k", roll, exp_roll);
    @(posedge clk); #1;
    chk("hit_k1", hit, v.exp_hit);
    @(posedge clk); #1;
    chk("hp_p1_k2", hp_p1, v.exp_p1);
    chk("hp_p2_k2", hp_p2, v.exp_p2);
    chk("done_k2", done, 1);
    @(posedge clk); #1;
    chk("done_k3", done, 0);
    chk("busy_k3", busy, 0);
    chk("over_k3", game_over, v.exp_over);
  endtask

  initial begin
    int nhit;
    vecs[0] = '{1'b0, 5'd7,  5'd16, 1'b1, 7'd100, 7'd93, 1'b0};
    vecs[1] = '{1'b1, 5'd15, 5'd0,  1'b0, 7'd100, 7'd93, 1'b0};
    vecs[2] = '{1'b1, 5'd0,  5'd31, 1'b1, 7'd100, 7'd93, 1'b0};
    vecs[3] = '{1'b1, 5'd31, 5'd20, 1'b1, 7'd69,  7'd93, 1'b0};
    vecs[4] = '{1'b0, 5'd31, 5'd16, 1'b1, 7'd69,  7'd62, 1'b0};
    vecs[5] = '{1'b0, 5'd31, 5'd16, 1'b1, 7'd69,  7'd31, 1'b0};
    vecs[6] = '{1'b0, 5'd26, 5'd16, 1'b1, 7'd69,  7'd5,  1'b0};
    vecs[7] = '{1'b0, 5'd15, 5'd16, 1'b1, 7'd69,  7'd0,  1'b1};

    resetn = 1'b0; start = 1'b0; attacker = 1'b0; new_game = 1'b0;
    dmg = '0; accu = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_hp_p1", hp_p1, 100);
    chk("rst_hp_p2", hp_p2, 100);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_over", game_over, 0);
    chk("rst_hit", hit, 0);
    chk("rst_roll", roll, 0);

    // async reset during APPLY aborts with no HP change
    @(negedge clk);
    start = 1'b1; attacker = 1'b0; dmg = 5'd20; accu = 5'd16;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    chk("abort_hp_p2", hp_p2, 100);
    chk("abort_busy", busy, 0);
    @(negedge clk); resetn = 1'b1;

    for (int i = 0; i < 8; i++) run_attack(vecs[i]);

    // start in OVER is ignored
    @(negedge clk);
    start = 1'b1; attacker = 1'b1; dmg = 5'd10; accu = 5'd16;
    repeat (4) @(posedge clk);
    #1 start = 1'b0;
    chk("over_busy", busy, 0);
    chk("over_hp_p1", hp_p1, 69);
    chk("over_hp_p2", hp_p2, 0);
    chk("over_hold", game_over, 1);

    @(negedge clk); new_game = 1'b1;
    @(posedge clk); #1 new_game = 1'b0;
    chk("ng_hp_p1", hp_p1, 100);
    chk("ng_hp_p2", hp_p2, 100);
    chk("ng_over", game_over, 0);
    chk("ng_hit", hit, 0);
    run_attack('{1'b1, 5'd10, 5'd16, 1'b1, 7'd90, 7'd100, 1'b0});

    // start held high; new_game lands during APPLY
    @(negedge clk);
    start = 1'b1; attacker = 1'b0; dmg = 5'd20; accu = 5'd10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    chk("ngapp_hp_p1", hp_p1, 100);
    chk("ngapp_hp_p2", hp_p2, 100);
    chk("ngapp_busy", busy, 0);
    chk("ngapp_done", done, 0);
    chk("ngapp_hit", hit, 0);

    // continuous start: one attack every 4 cycles, hit == roll < 10
    dmg = 5'd0;
    nhit = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      exp_roll = lfsr_m[3:0];
      @(posedge clk); #1;
      chk("bb_roll", roll, exp_roll);
      chk("bb_busy", busy, 1);
      @(posedge clk); #1;
      chk("bb_hit", hit, (exp_roll < 4'd10) ? 1 : 0);
      if (hit) nhit++;
      @(posedge clk); #1;
      chk("bb_done", done, 1);
      @(posedge clk); #1;
      chk("bb_idle", busy, 0);
    end
    start = 1'b0;
    chk("bb_hp_p1", hp_p1, 100);
    chk("bb_hp_p2", hp_p2, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
